// File: rtl/mult_bus_arbiter.sv
// Round-robin bus master sharing one peripheral_mult between two requesters.
// Optional poll timeout is enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_bus_arbiter #(
  parameter logic [4:0] ADDR_A    = 5'h04,
  parameter logic [4:0] ADDR_B    = 5'h08,
  parameter logic [4:0] ADDR_INIT = 5'h0C,
  parameter logic [4:0] ADDR_RES  = 5'h10,
  parameter logic [4:0] ADDR_DONE = 5'h14,
  parameter int         TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_result,
  output logic        resp1_valid,
  output logic [31:0] resp1_result,
  output logic        resp_err,
  output logic        busy,
  output logic        bus_cs,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [4:0]  bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, INIT_HI, INIT_LO, POLL_RD, POLL_WAIT, RES_RD, RES_WAIT, RESP
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        pick;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [31:0] res0_q, res0_d, res1_q, res1_d;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic       err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  assign busy         = (state_q != IDLE);
  assign resp0_result = res0_q;
  assign resp1_result = res1_q;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res0_d      = res0_q;
    res1_d      = res1_q;
    pick        = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp_err    = 1'b0;
    bus_cs      = 1'b0;
    bus_rd      = 1'b0;
    bus_wr      = 1'b0;
    bus_addr    = 5'h00;
    bus_wdata   = 16'h0000;
`ifdef MULT_ARB_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the requester not served last wins.
          pick       = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          req0_ready = ~pick;
          req1_ready = pick;
          gnt_d      = pick;
          last_d     = pick;
          a_d        = pick ? req1_a : req0_a;
          b_d        = pick ? req1_b : req0_b;
          state_d    = WR_A;
        end
      end
      WR_A: begin
        bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_A; bus_wdata = a_q;
        state_d = WR_B;
      end
      WR_B: begin
        bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_B; bus_wdata = b_q;
        state_d = INIT_HI;
      end
      INIT_HI: begin
        bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_INIT; bus_wdata = 16'h0001;
        state_d = INIT_LO;
      end
      INIT_LO: begin
        bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_INIT; bus_wdata = 16'h0000;
`ifdef MULT_ARB_TIMEOUT_EN
        poll_cnt_d = 8'h00;
`endif
        state_d = POLL_RD;
      end
      POLL_RD: begin
        bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = ADDR_DONE;
        state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (bus_rdata[0]) begin
          state_d = RES_RD;
        end else begin
`ifdef MULT_ARB_TIMEOUT_EN
          poll_cnt_d = poll_cnt_q + 8'd1;
          if (poll_cnt_q + 8'd1 == TIMEOUT_CNT) begin
            if (gnt_q) res1_d = 32'h0;
            else       res0_d = 32'h0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = POLL_RD;
          end
`else
          state_d = POLL_RD;
`endif
        end
      end
      RES_RD: begin
        bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = ADDR_RES;
        state_d = RES_WAIT;
      end
      RES_WAIT: begin
        if (gnt_q) res1_d = bus_rdata;
        else       res0_d = bus_rdata;
`ifdef MULT_ARB_TIMEOUT_EN
        err_d = 1'b0;
`endif
        state_d = RESP;
      end
      RESP: begin
        resp0_valid = ~gnt_q;
        resp1_valid = gnt_q;
`ifdef MULT_ARB_TIMEOUT_EN
        resp_err = err_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      res0_q  <= 32'h0;
      res1_q  <= 32'h0;
`ifdef MULT_ARB_TIMEOUT_EN
      poll_cnt_q <= 8'h00;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
`ifdef MULT_ARB_TIMEOUT_EN
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // Operand holding registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

endmodule
